execute_muldiv: RTL
===================

Name: execute_muldiv

Overview:
Next-generation EX pipeline stage with parametrised datapath width, and the successor to the single-cycle ALU execute stage. It keeps the single-cycle ALU, the operand forwarding from EX/ME and the EX/ME pipeline register. It adds an iterative unsigned multiply/divide unit with HI/LO registers and real stall generation on Stall_EX. The block sits between the decode stage and the memory stage; the hazard unit ORs Stall_EX into AnyStall.

Parameters:
WIDTH, 32, datapath width (even, >=8)
REGBITS, 5, register-specifier width
CNTBITS, 6, iteration-counter width; must satisfy 2**CNTBITS > WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of pipeline regs; aborts mul/div
AnyStall  in  1  global stall (includes Stall_EX)
AluSrc_ID, RegDst_ID  in  1  immediate select / Rd-vs-Rt destination select
AluControl_ID  in  4  operation code
SignImm_ID  in  WIDTH  sign-extended immediate; shamt = SignImm_ID[10:6]
RegWrite_ID, MemWrite_ID, MemToReg_ID  in  1  control bits
RdDatA_ID, RdDatB_ID  in  WIDTH  register-file read data
Rs_ID, Rt_ID, Rd_ID  in  REGBITS  specifiers
WriteReg_ME  in  REGBITS  ME-stage destination
RegWrite_ME  in  1  ME-stage write enable
ResultRdDat_ME  in  WIDTH  ME-stage result / load data
Result_EX, WrDat_EX  out  WIDTH  registered ALU result, store data
WriteReg_EX  out  REGBITS  registered destination
RegWrite_EX, MemToReg_EX, MemWrite_EX  out  1  registered control bits
Stall_EX  out  1  EX busy, hold upstream

Behaviour:
- Forwarding for operand a (Rs) and forwarded-Rt (fb):
  - Rs/Rt != 0 and matching WriteReg_EX with RegWrite_EX -> use Result_EX (priority).
  - Else matching WriteReg_ME with RegWrite_ME -> use ResultRdDat_ME.
  - Else use register-file data.
  - Load-use interlock is external.
- b = AluSrc_ID ? SignImm_ID : fb.
- WrDat pipeline input = fb, i.e. forwarded store data.
- ALU codes:
  - 0000 and; 0001 or; 0101 xor.
  - 0010 add; 0110 sub (a + ~b + 1).
  - 0111 slt: zero-extended 1-bit signed a<b, taken from overflow-corrected sign.
  - 0011 a<<b[4:0]; 0100 a>>b[4:0].
  - 1100 sll shamt; 1101 srl shamt; 1110 sra shamt.
  - 1001 lui: {b[15:0], zeros}.
  - 1010 mfhi; 1011 mflo.
  - 1000 multu; 1111 divu.
  - Undefined codes -> result 0.
- FSM states IDLE, BUSY, DONE; counter cnt.
- start = (state==IDLE) & (op is 1000 or 1111) & !flush.
  - Loads a and fb into the multiplier/divider registers; cnt=0; next state BUSY.
- BUSY: one radix-2 step per cycle.
  - multu: shift-add.
  - divu: restoring, quotient in LO, remainder in HI.
  - After step WIDTH-1 (cnt==WIDTH-1): HI/LO written at that edge; next state DONE.
- DONE: hold while AnyStall=1; go IDLE when AnyStall=0.
  - The instruction advances on that same edge, so there is no restart.
- Stall_EX = start | (state==BUSY).
  - Stall_EX is high for exactly WIDTH+1 cycles per mul/div.
  - Stall_EX is low in DONE.
- divu by zero: LO = all ones, HI = dividend. No exception.
- mfhi/mflo in DONE or later see the new HI/LO.
  - Back-to-back mult then mflo needs no extra stall beyond Stall_EX.
- Pipeline registers:
  - Hold their value when AnyStall=1.
  - Otherwise load result, fb, RegDst mux, RegWrite_ID, MemToReg_ID, MemWrite_ID.
  - flush clears them to 0 (flush wins over AnyStall).
- flush during BUSY/DONE: state->IDLE, cnt=0, HI/LO unchanged.
- reset: async; all outputs 0, state IDLE, cnt 0, HI=LO=0, Stall_EX=0.
  - Reset mid-operation abandons the operation.

Test Plan:
- multu a=0x00012345, b=0x00001000 (WIDTH=32) -> Stall_EX high 33 cycles; then mflo=0x12345000, mfhi=0x00000000.
- multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; divu 100/7 -> LO=14, HI=2; divu 5/0 -> LO=0xFFFFFFFF, HI=5.
- add with Rs matching both WriteReg_EX and WriteReg_ME (both writing), Result_EX=7, ResultRdDat_ME=9 -> EX value 7 used; Rs=0 -> no forwarding.
- flush at BUSY cycle 10 of a divu -> Stall_EX low next cycle, pipeline regs 0, HI/LO keep the prior values.
- External AnyStall held 3 cycles during DONE -> no restart, HI/LO stable, instruction leaves on the first non-stalled edge.
- reset asserted asynchronously mid-multu -> outputs, HI, LO and Stall_EX all 0 immediately; slt(-1, 1)=1 and sra(0x80000000, 4)=0xF8000000 after release.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv: EX pipeline stage. Single-cycle ALU with EX/ME operand
// forwarding, an iterative unsigned multiply/divide unit with HI/LO, stall
// generation on Stall_EX, and the EX/ME pipeline register.
module execute_muldiv #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5,
    parameter int CNTBITS = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               AnyStall,
    input  logic               AluSrc_ID,
    input  logic               RegDst_ID,
    input  logic [3:0]         AluControl_ID,
    input  logic [WIDTH-1:0]   SignImm_ID,
    input  logic               RegWrite_ID,
    input  logic               MemWrite_ID,
    input  logic               MemToReg_ID,
    input  logic [WIDTH-1:0]   RdDatA_ID,
    input  logic [WIDTH-1:0]   RdDatB_ID,
    input  logic [REGBITS-1:0] Rs_ID,
    input  logic [REGBITS-1:0] Rt_ID,
    input  logic [REGBITS-1:0] Rd_ID,
    input  logic [REGBITS-1:0] WriteReg_ME,
    input  logic               RegWrite_ME,
    input  logic [WIDTH-1:0]   ResultRdDat_ME,
    output logic [WIDTH-1:0]   Result_EX,
    output logic [WIDTH-1:0]   WrDat_EX,
    output logic [REGBITS-1:0] WriteReg_EX,
    output logic               RegWrite_EX,
    output logic               MemToReg_EX,
    output logic               MemWrite_EX,
    output logic               Stall_EX
);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLLV = 4'b0011, OP_SRLV = 4'b0100, OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_LUI  = 4'b1001, OP_MFHI = 4'b1010, OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_SLL  = 4'b1100, OP_SRL  = 4'b1101, OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    localparam logic [CNTBITS-1:0] LAST_STEP = CNTBITS'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

    mdState_t           state, stateNext;
    logic [CNTBITS-1:0] cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   mdAcc, mdQ, mdM;
    logic               mdIsDiv;
    logic [WIDTH-1:0]   srcA, fwdB, srcB, aluResult, diff;
    logic [WIDTH-1:0]   stepAcc, stepQ;
    logic [WIDTH:0]     mulSum, remShift, remDiff;
    logic [4:0]         shamt;
    logic               sltBit, isMdOp, start;

    // Operand forwarding: the EX/ME register wins over the ME stage; r0 never forwards.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch can be inferred.
        srcA = RdDatA_ID;
        fwdB = RdDatB_ID;
        if (Rs_ID != '0 && RegWrite_EX && Rs_ID == WriteReg_EX)
            srcA = Result_EX;
        else if (Rs_ID != '0 && RegWrite_ME && Rs_ID == WriteReg_ME)
            srcA = ResultRdDat_ME;
        if (Rt_ID != '0 && RegWrite_EX && Rt_ID == WriteReg_EX)
            fwdB = Result_EX;
        else if (Rt_ID != '0 && RegWrite_ME && Rt_ID == WriteReg_ME)
            fwdB = ResultRdDat_ME;
        srcB = AluSrc_ID ? SignImm_ID : fwdB;
    end

    assign shamt  = SignImm_ID[10:6];
    assign diff   = srcA + ~srcB + WIDTH'(1);
    // Signed less-than is the difference sign corrected for two's-complement overflow.
    assign sltBit = diff[WIDTH-1]
                  ^ ((srcA[WIDTH-1] ^ srcB[WIDTH-1]) & (diff[WIDTH-1] ^ srcA[WIDTH-1]));

    // Single-cycle ALU; multu/divu themselves produce a zero result.
    always_comb begin
        aluResult = '0;
        case (AluControl_ID)
            OP_AND:  aluResult = srcA & srcB;
            OP_OR:   aluResult = srcA | srcB;
            OP_XOR:  aluResult = srcA ^ srcB;
            OP_ADD:  aluResult = srcA + srcB;
            OP_SUB:  aluResult = diff;
            OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, sltBit};
            OP_SLLV: aluResult = srcA << srcB[4:0];
            OP_SRLV: aluResult = srcA >> srcB[4:0];
            OP_SLL:  aluResult = srcA << shamt;
            OP_SRL:  aluResult = srcA >> shamt;
            OP_SRA:  aluResult = WIDTH'($signed(srcA) >>> shamt);
            OP_LUI:  aluResult = srcB << 16;
            OP_MFHI: aluResult = hi;
            OP_MFLO: aluResult = lo;
            default: aluResult = '0;
        endcase
    end

    assign isMdOp   = (AluControl_ID == OP_MULTU) || (AluControl_ID == OP_DIVU);
    assign start    = (state == IDLE) && isMdOp && !flush && !reset;
    assign Stall_EX = start || (state == BUSY);

    // Mul/div sequencer: IDLE -> BUSY for WIDTH steps -> DONE until the instruction leaves.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = BUSY;
            BUSY:    if (cnt == LAST_STEP) stateNext = DONE;
            DONE:    if (!AnyStall) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    assign mulSum   = {1'b0, mdAcc} + {1'b0, mdM};
    assign remShift = {mdAcc, mdQ[WIDTH-1]};
    assign remDiff  = remShift - {1'b0, mdM};

    // One radix-2 step: shift-add multiply or restoring divide (borrow = remDiff MSB).
    always_comb begin
        stepAcc = '0;
        stepQ   = '0;
        if (mdIsDiv) begin
            if (!remDiff[WIDTH])
                {stepAcc, stepQ} = {remDiff[WIDTH-1:0], mdQ[WIDTH-2:0], 1'b1};
            else
                {stepAcc, stepQ} = {remShift[WIDTH-1:0], mdQ[WIDTH-2:0], 1'b0};
        end else if (mdQ[0]) begin
            {stepAcc, stepQ} = {mulSum, mdQ[WIDTH-1:1]};
        end else begin
            {stepAcc, stepQ} = {1'b0, mdAcc, mdQ[WIDTH-1:1]};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Mul/div working registers and HI/LO; HI/LO change only on the final step.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the working registers are reset as well so an abandoned operation leaves nothing behind.
        if (reset) begin
            cnt     <= '0;
            mdAcc   <= '0;
            mdQ     <= '0;
            mdM     <= '0;
            mdIsDiv <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            cnt     <= '0;
            mdIsDiv <= (AluControl_ID == OP_DIVU);
            mdAcc   <= '0;
            mdQ     <= (AluControl_ID == OP_DIVU) ? srcA : fwdB;
            mdM     <= (AluControl_ID == OP_DIVU) ? fwdB : srcA;
        end else if (state == BUSY) begin
            cnt   <= cnt + CNTBITS'(1);
            mdAcc <= stepAcc;
            mdQ   <= stepQ;
            if (cnt == LAST_STEP) begin
                hi <= stepAcc;
                lo <= stepQ;
            end
        end
    end

    // EX/ME pipeline register: flush clears, stall holds, otherwise load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            Result_EX   <= '0;
            WrDat_EX    <= '0;
            WriteReg_EX <= '0;
            RegWrite_EX <= 1'b0;
            MemToReg_EX <= 1'b0;
            MemWrite_EX <= 1'b0;
        end else if (!AnyStall) begin
            Result_EX   <= aluResult;
            WrDat_EX    <= fwdB;
            WriteReg_EX <= RegDst_ID ? Rd_ID : Rt_ID;
            RegWrite_EX <= RegWrite_ID;
            MemToReg_EX <= MemToReg_ID;
            MemWrite_EX <= MemWrite_ID;
        end
    end

endmodule
